// File: rtl/cdc_tx_pkg.sv
// Shared types and default sizing for the toggle req/ack CDC transmitter.
package cdc_tx_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int unsigned DW_DEF          = 8;
    localparam int unsigned SYNC_STAGE_DEF  = 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/cdc_sync_ah.sv
// Single-bit multi-flop synchronizer, asynchronous active-high reset to 0.
module cdc_sync_ah #(
    parameter int unsigned SYNC_STAGE = 2
) (
    input  logic I_CLK,
    input  logic I_RST,
    input  logic I_D,
    output logic O_Q
);

    if (SYNC_STAGE < 2) begin : g_bad_depth
        $error("cdc_sync_ah: SYNC_STAGE must be >= 2");
    end

    logic [SYNC_STAGE-1:0] chain_q;
    logic [SYNC_STAGE-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGE-2:0], I_D};
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign O_Q = chain_q[SYNC_STAGE-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack CDC handshake: holds a word on O_DATA, toggles O_REQ,
// waits for the synchronized ack toggle. Optional ack timeout flag via CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx
    import cdc_tx_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned SYNC_STAGE  = SYNC_STAGE_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_VALID,
    output logic          O_READY,
    input  logic [DW-1:0] I_DATA,
    output logic [DW-1:0] O_DATA,
    output logic          O_REQ,
    input  logic          I_ACK,
    output logic          O_DONE,
    output logic          O_TIMEOUT,
    input  logic          I_TIMEOUT_CLR
);

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          req_q, req_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          ack_s;
    logic          accept;

    cdc_sync_ah #(
        .SYNC_STAGE(SYNC_STAGE)
    ) u_ack_sync (
        .I_CLK(I_CLK),
        .I_RST(I_RST),
        .I_D  (I_ACK),
        .O_Q  (ack_s)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        accept  = (state_q == IDLE) && I_VALID && ready_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    data_d  = I_DATA;
                    req_d   = ~req_q;
                    ready_d = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                ready_d = 1'b0;
                // Ack matching our req level means the destination has latched the word.
                if (ack_s == req_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign O_READY = ready_q;
    assign O_DATA  = data_q;
    assign O_REQ   = req_q;
    assign O_DONE  = done_q;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Flag is raised only on the cycle the count reaches the limit, so a clear
    // while the transfer is still stalled sticks.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (I_TIMEOUT_CLR) begin
            timeout_d = 1'b0;
        end
        if (accept) begin
            cnt_d = '0;
        end else if ((state_q == WAIT_ACK) && (cnt_q != CW'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(TIMEOUT_CYC)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign O_TIMEOUT = timeout_q;
`else
    logic unused_timeout_clr;

    assign unused_timeout_clr = I_TIMEOUT_CLR;
    assign O_TIMEOUT          = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed scoreboard bench for cdc_handshake_tx; destination modelled as a 1-cycle ack loopback.
module tb_cdc_handshake_tx;

    logic       I_CLK = 1'b0;
    logic       I_RST = 1'b1;
    logic       I_VALID = 1'b0;
    logic       O_READY;
    logic [7:0] I_DATA = 8'h00;
    logic [7:0] O_DATA;
    logic       O_REQ;
    logic       I_ACK;
    logic       O_DONE;
    logic       O_TIMEOUT;
    logic       I_TIMEOUT_CLR = 1'b0;

    logic       ack_en = 1'b1;
    logic       ack_q;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       busy = 1'b0;
    logic       exp_req = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       last_acc = 1'b0;

    cdc_handshake_tx #(
        .DW(8),
        .SYNC_STAGE(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .I_CLK(I_CLK),
        .I_RST(I_RST),
        .I_VALID(I_VALID),
        .O_READY(O_READY),
        .I_DATA(I_DATA),
        .O_DATA(O_DATA),
        .O_REQ(O_REQ),
        .I_ACK(I_ACK),
        .O_DONE(O_DONE),
        .O_TIMEOUT(O_TIMEOUT),
        .I_TIMEOUT_CLR(I_TIMEOUT_CLR)
    );

    always #5 I_CLK = ~I_CLK;

    // Destination: returns the req level one cycle later, shares the reset.
    always @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) ack_q <= 1'b0;
        else if (ack_en) ack_q <= O_REQ;
    end
    assign I_ACK = ack_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       acc;
        logic [7:0] acc_data;
        logic       exp_done;
        acc      = I_VALID && O_READY && !I_RST;
        acc_data = I_DATA;
        @(posedge I_CLK);
        cyc++;
        last_acc = acc;
        if (acc) begin
            busy     = 1'b1;
            exp_req  = ~exp_req;
            exp_data = acc_data;
            sb.push_back('{data: acc_data, due: ack_en ? cyc + 4 : 0});
        end
        @(negedge I_CLK);
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        check("done", 32'(O_DONE), 32'(exp_done));
        if (exp_done) begin
            check("done_data", 32'(O_DATA), 32'(sb[0].data));
            void'(sb.pop_front());
            busy = 1'b0;
        end
        check("ready", 32'(O_READY), 32'(!busy && !I_RST));
        check("req", 32'(O_REQ), 32'(exp_req));
        check("data", 32'(O_DATA), 32'(exp_data));
`ifndef CDC_TX_TIMEOUT_EN
        check("timeout_tied", 32'(O_TIMEOUT), 32'd0);
`endif
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        I_DATA  = d;
        I_VALID = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        check("send_accept", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge I_CLK);
        check("rst_ready", 32'(O_READY), 32'd0);
        check("rst_req", 32'(O_REQ), 32'd0);
        check("rst_data", 32'(O_DATA), 32'd0);
        check("rst_done", 32'(O_DONE), 32'd0);
        check("rst_timeout", 32'(O_TIMEOUT), 32'd0);
        I_RST = 1'b0;
        tick();
        check("ready_after_rst", 32'(O_READY), 32'd1);

        // Single word, ack looped back; done latency checked in tick()
        send(8'hA5);
        I_VALID = 1'b0;
        check("a5_data", 32'(O_DATA), 32'hA5);
        check("a5_req", 32'(O_REQ), 32'd1);
        drain();

        // Back-to-back with I_VALID held high
        send(8'h01);
        send(8'h02);
        send(8'h03);
        I_VALID = 1'b0;
        drain();
        check("b2b_req_parity", 32'(O_REQ), 32'd0);

        // Data change during WAIT_ACK is ignored
        send(8'h3C);
        I_DATA = 8'hFF;
        tick();
        tick();
        check("hold_data", 32'(O_DATA), 32'h3C);
        I_VALID = 1'b0;
        drain();

        // Reset in WAIT_ACK
        send(8'h5A);
        I_VALID = 1'b0;
        tick();
        I_RST = 1'b1;
        #1;
        check("midrst_req", 32'(O_REQ), 32'd0);
        check("midrst_ready", 32'(O_READY), 32'd0);
        check("midrst_data", 32'(O_DATA), 32'd0);
        check("midrst_done", 32'(O_DONE), 32'd0);
        sb.delete();
        busy     = 1'b0;
        exp_req  = 1'b0;
        exp_data = 8'h00;
        tick();
        tick();
        I_RST = 1'b0;
        tick();
        send(8'h77);
        I_VALID = 1'b0;
        drain();

`ifdef CDC_TX_TIMEOUT_EN
        // No ack: flag after 16 WAIT_ACK cycles, late ack still completes
        ack_en = 1'b0;
        send(8'hC3);
        I_VALID = 1'b0;
        repeat (15) tick();
        check("to_before", 32'(O_TIMEOUT), 32'd0);
        tick();
        check("to_set", 32'(O_TIMEOUT), 32'd1);
        repeat (3) tick();
        check("to_sticky", 32'(O_TIMEOUT), 32'd1);
        check("to_ready_low", 32'(O_READY), 32'd0);
        ack_en    = 1'b1;
        sb[0].due = cyc + 4;
        drain();
        check("to_after_done", 32'(O_TIMEOUT), 32'd1);
        I_TIMEOUT_CLR = 1'b1;
        tick();
        I_TIMEOUT_CLR = 1'b0;
        check("to_cleared", 32'(O_TIMEOUT), 32'd0);
`else
        I_TIMEOUT_CLR = 1'b1;
        tick();
        I_TIMEOUT_CLR = 1'b0;
        check("to_disabled", 32'(O_TIMEOUT), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
